contador_ctrl: RTL and testbench

//  Sequencer for the 4-bit counter datapath: loads a start value, runs the count at a

---
 rtl/contador_pkg.sv | 14 +
 rtl/contador_sinc.sv | 23 ++
 rtl/contador_ctrl.sv | 133 +++++++++++++
 tb/tb_contador_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared state encoding and mode constants for the contador counter sequencer.
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/contador_sinc.sv
// WIDTH-bit counter register: load has priority over increment; async active-low clear.
module contador_sinc #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/contador_ctrl.sv
// Counter sequencer: FSM, prescaler, start-time capture of config and done pulse generation.
module contador_ctrl
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PRESC = 1
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_lim;
    logic [WIDTH-1:0] r_load;
    logic             r_mode;
    logic             r_busy;
    logic             r_done;

    logic             w_tick;
    logic             w_term;
    logic             w_start_ok;
    logic             w_en;
    logic             w_load;
    logic [WIDTH-1:0] w_d;

    assign w_tick     = (r_state == RUN) && (r_presc == PRESC_MAX);
    assign w_term     = (Q == r_lim);
    assign w_start_ok = start && !stop;

    // Datapath control; stop freezes Q even on a tick edge.
    always_comb begin
        w_en   = 1'b0;
        w_load = 1'b0;
        w_d    = '0;
        if (abort) begin
            w_load = 1'b1;
        end else if ((r_state == RUN) && !stop && w_tick) begin
            if (!w_term) begin
                w_en = 1'b1;
            end else if (r_mode == MODE_RELOAD) begin
                w_load = 1'b1;
                w_d    = r_load;
            end
        end else if (w_start_ok && ((r_state == IDLE) || (r_state == DONE))) begin
            w_load = 1'b1;
            w_d    = load_val;
        end
    end

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_lim   <= '0;
            r_load  <= '0;
            r_mode  <= MODE_ONESHOT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= IDLE;
                r_presc <= '0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE, DONE: begin
                        if (w_start_ok) begin
                            r_state <= RUN;
                            r_lim   <= limit;
                            r_load  <= load_val;
                            r_mode  <= mode;
                            r_presc <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            r_state <= PAUSE;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            if (w_term) begin
                                r_done <= 1'b1;
                                if (r_mode == MODE_ONESHOT) begin
                                    r_state <= DONE;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (w_start_ok) begin
                            r_state <= RUN;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    contador_sinc #(
        .WIDTH(WIDTH)
    ) u_sinc (
        .clk  (clk),
        .CLR  (CLR),
        .en   (w_en),
        .load (w_load),
        .d    (w_d),
        .q    (Q)
    );

    assign busy  = r_busy;
    assign done  = r_done;
    assign state = r_state;

endmodule

// File: tb/tb_contador_ctrl.sv
// Directed bench for contador_ctrl: vector table on a PRESC=1 instance, hand sequences on both.
module tb_contador_ctrl;

    logic       clk;
    logic       CLR;
    logic       start;
    logic       stop;
    logic       abort;
    logic       mode;
    logic [3:0] load_val;
    logic [3:0] limit;

    logic [3:0] q1, q3;
    logic       busy1, busy3, done1, done3;
    logic [1:0] st1, st3;

    int checks;
    int failures;

    contador_ctrl #(.WIDTH(4), .PRESC(1)) u_p1 (
        .clk(clk), .CLR(CLR), .start(start), .stop(stop), .abort(abort), .mode(mode),
        .load_val(load_val), .limit(limit), .Q(q1), .busy(busy1), .done(done1), .state(st1)
    );

    contador_ctrl #(.WIDTH(4), .PRESC(3)) u_p3 (
        .clk(clk), .CLR(CLR), .start(start), .stop(stop), .abort(abort), .mode(mode),
        .load_val(load_val), .limit(limit), .Q(q3), .busy(busy3), .done(done3), .state(st3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       sp;
        logic       ab;
        logic       md;
        logic [3:0] lv;
        logic [3:0] lm;
        logic [3:0] q;
        logic       bz;
        logic       dn;
        logic [1:0] s;
    } vec_t;

    vec_t vq[$];

    function automatic void add(int st, int sp, int ab, int md, int lv, int lm,
                                int q, int bz, int dn, int s);
        vec_t v;
        v.st = (st != 0);
        v.sp = (sp != 0);
        v.ab = (ab != 0);
        v.md = (md != 0);
        v.lv = 4'(lv);
        v.lm = 4'(lm);
        v.q  = 4'(q);
        v.bz = (bz != 0);
        v.dn = (dn != 0);
        v.s  = 2'(s);
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic ab, input logic md,
                         input logic [3:0] lv, input logic [3:0] lm);
        start    = st;
        stop     = sp;
        abort    = ab;
        mode     = md;
        load_val = lv;
        limit    = lm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input string name, input int idx, input int q, input int bz,
                           input int dn, input int s);
        check({name, ".Q"}, idx, int'(q1), q);
        check({name, ".busy"}, idx, int'(busy1), bz);
        check({name, ".done"}, idx, int'(done1), dn);
        check({name, ".state"}, idx, int'(st1), s);
    endtask

    initial begin
        int p3q[4];
        checks   = 0;
        failures = 0;
        CLR      = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        #3;
        expect1("reset", 0, 0, 0, 0, 0);
        check("reset_p3.Q", 0, int'(q3), 0);
        step();
        CLR = 1'b1;

        // One-shot 3..7; live inputs scrambled after start to prove capture.
        add(1, 0, 0, 0,  3,  7,  3, 1, 0, 1);
        add(0, 0, 0, 1, 15,  0,  4, 1, 0, 1);
        add(0, 0, 0, 1, 15,  0,  5, 1, 0, 1);
        add(0, 0, 0, 1, 15,  0,  6, 1, 0, 1);
        add(0, 0, 0, 1, 15,  0,  7, 1, 0, 1);
        add(0, 0, 0, 1, 15,  0,  7, 0, 1, 3);
        add(0, 0, 0, 1, 15,  0,  7, 0, 0, 3);
        add(0, 0, 1, 0,  0,  0,  0, 0, 0, 0);
        // Auto-reload 2..4
        add(1, 0, 0, 1,  2,  4,  2, 1, 0, 1);
        add(0, 0, 0, 0,  9, 11,  3, 1, 0, 1);
        add(0, 0, 0, 0,  9, 11,  4, 1, 0, 1);
        add(0, 0, 0, 0,  9, 11,  2, 1, 1, 1);
        add(0, 0, 0, 0,  9, 11,  3, 1, 0, 1);
        add(0, 0, 0, 0,  9, 11,  4, 1, 0, 1);
        add(0, 0, 0, 0,  9, 11,  2, 1, 1, 1);
        add(0, 0, 0, 0,  9, 11,  3, 1, 0, 1);
        add(0, 0, 1, 0,  0,  0,  0, 0, 0, 0);
        // Wrap 14,15,0,1 then restart from DONE with new config
        add(1, 0, 0, 0, 14,  1, 14, 1, 0, 1);
        add(0, 0, 0, 0,  0,  0, 15, 1, 0, 1);
        add(0, 0, 0, 0,  0,  0,  0, 1, 0, 1);
        add(0, 0, 0, 0,  0,  0,  1, 1, 0, 1);
        add(0, 0, 0, 0,  0,  0,  1, 0, 1, 3);
        add(1, 0, 0, 0,  3,  4,  3, 1, 0, 1);
        add(0, 0, 0, 0,  0,  0,  4, 1, 0, 1);
        add(0, 0, 0, 0,  0,  0,  4, 0, 1, 3);
        add(0, 0, 1, 0,  0,  0,  0, 0, 0, 0);
        // load_val == limit: terminal on first tick
        add(1, 0, 0, 0,  9,  9,  9, 1, 0, 1);
        add(0, 0, 0, 0,  0,  0,  9, 0, 1, 3);
        add(0, 0, 1, 0,  0,  0,  0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].st, vq[i].sp, vq[i].ab, vq[i].md, vq[i].lv, vq[i].lm);
            step();
            expect1("vec", i, int'(vq[i].q), int'(vq[i].bz), int'(vq[i].dn), int'(vq[i].s));
        end

        // Pause/resume
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd9); step(); expect1("pause", 0, 3, 1, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0); step(); expect1("pause", 1, 4, 1, 0, 1);
        step(); expect1("pause", 2, 5, 1, 0, 1);
        stop = 1'b1; step(); expect1("pause", 3, 5, 1, 0, 2);
        stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            expect1("frozen", i, 5, 1, 0, 2);
        end
        stop = 1'b1; step(); expect1("pause", 4, 5, 1, 0, 2);
        stop = 1'b0; start = 1'b1; step(); expect1("pause", 5, 5, 1, 0, 1);
        start = 1'b0; step(); expect1("pause", 6, 6, 1, 0, 1);
        step(); expect1("pause", 7, 7, 1, 0, 1);
        start = 1'b1; stop = 1'b1; step(); expect1("pause", 8, 7, 1, 0, 2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0); step(); expect1("pause", 9, 0, 0, 0, 0);

        // Abort on the terminal tick suppresses done
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2); step(); expect1("abtick", 0, 1, 1, 0, 1);
        start = 1'b0; step(); expect1("abtick", 1, 2, 1, 0, 1);
        abort = 1'b1; step(); expect1("abtick", 2, 0, 0, 0, 0);
        abort = 1'b0; step(); expect1("abtick", 3, 0, 0, 0, 0);

        // PRESC=3 wrap: each value held 3 clocks
        p3q[0] = 14; p3q[1] = 15; p3q[2] = 0; p3q[3] = 1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd14, 4'd1);
        for (int i = 0; i < 12; i++) begin
            step();
            start = 1'b0;
            check("p3.Q", i, int'(q3), p3q[i / 3]);
            check("p3.done", i, int'(done3), 0);
            check("p3.state", i, int'(st3), 1);
        end
        step();
        check("p3_end.Q", 0, int'(q3), 1);
        check("p3_end.done", 0, int'(done3), 1);
        check("p3_end.state", 0, int'(st3), 3);
        check("p3_end.busy", 0, int'(busy3), 0);
        step();
        check("p3_end.done", 1, int'(done3), 0);
        abort = 1'b1; step(); abort = 1'b0;

        // Asynchronous reset mid-RUN, away from any clock edge
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd9); step();
        start = 1'b0; step(); expect1("prerst", 0, 4, 1, 0, 1);
        #2;
        CLR = 1'b0;
        #1;
        expect1("asyncrst", 0, 0, 0, 0, 0);
        check("asyncrst_p3.Q", 0, int'(q3), 0);
        check("asyncrst_p3.state", 0, int'(st3), 0);
        check("asyncrst_p3.busy", 0, int'(busy3), 0);
        step();
        CLR = 1'b1;
        step();
        expect1("postrst", 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
